// File: rtl/pingpong_pkg.sv
// pingpong_pkg
// Shared definitions for the two-bank ping-pong buffer: the per-bank
// ownership state, default geometry constants and small state predicates
// used by the controller.
package pingpong_pkg;

    // Ownership state of one bank. The encoding keeps the two "writable"
    // states and the two "readable" states disjoint, so one bank can never
    // be written and read in the same cycle.
    typedef enum logic [1:0] {
        BANK_FREE     = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

    localparam int DEFAULT_DEPTH  = 4;
    localparam int DEFAULT_DATA_W = 8;

    // Bank may accept producer words.
    function automatic logic bank_writable(input bank_state_e s);
        return (s == BANK_FREE) || (s == BANK_FILLING);
    endfunction

    // Bank holds a complete set of words waiting to be read or being read.
    function automatic logic bank_readable(input bank_state_e s);
        return (s == BANK_FULL) || (s == BANK_DRAINING);
    endfunction

endpackage

// File: rtl/pingpong_bank_ram.sv
// pingpong_bank_ram
// One bank of the ping-pong buffer: synchronous RAM with one write port and
// one read port. The read data register only updates on re, so the consumer
// can stall while the last read word stays on rdata.
// Ports:
//   clk, reset        clock and synchronous active-high reset (output reg only)
//   we, waddr, wdata  write strobe, word index, data
//   re, raddr         read strobe, word index
//   rdata             registered read data, held while re is low
module pingpong_bank_ram
    import pingpong_pkg::*;
#(
    parameter int  DATA_W = DEFAULT_DATA_W,
    parameter int  DEPTH  = DEFAULT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;

    // Storage array write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read data register: loads on re, otherwise holds for a stalled consumer.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_r <= {DATA_W{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/pingpong_ctrl.sv
// pingpong_ctrl
// Bank-sequencing controller for a two-bank ping-pong buffer. It tracks the
// ownership state of each bank, the write/read bank pointers and word
// counters, and drives strobes/addresses for two external bank RAMs. Words
// are only released to the consumer in whole banks.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   in_valid / in_ready      producer handshake
//   wr_en, wr_bank, wr_addr  write strobe, bank select, word index
//   rd_en, rd_bank, rd_addr  read strobe, bank select, word index
//   out_valid / out_ready    consumer handshake (data comes from the RAMs)
//   bank_full                per-bank FULL-or-DRAINING flag
//   level                    number of banks FULL or DRAINING (0..2)
module pingpong_ctrl
    import pingpong_pkg::*;
#(
    parameter int  DATA_W = DEFAULT_DATA_W,
    parameter int  DEPTH  = DEFAULT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              rd_en,
    output logic              rd_bank,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        bank_full,
    output logic [1:0]        level
);

    // Reject geometries the attached RAMs cannot support.
    if (DEPTH < 2 || DATA_W < 1) begin : g_param_check
        $error("pingpong_ctrl: DEPTH must be >= 2 and DATA_W >= 1");
    end

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    bank_state_e       state_r [2];
    logic              wr_bank_r;
    logic              rd_bank_r;
    logic [ADDR_W-1:0] wr_cnt_r;
    logic [ADDR_W-1:0] rd_cnt_r;
    logic              out_valid_r;

    logic              in_ready_s;
    logic              wr_en_s;
    logic              rd_en_s;
    logic [1:0]        bank_full_s;

    // Handshake and strobe decode from the registered bank states.
    always_comb begin
        in_ready_s = 1'b0;
        wr_en_s    = 1'b0;
        rd_en_s    = 1'b0;
        if (reset) begin
            in_ready_s = 1'b0;
            wr_en_s    = 1'b0;
            rd_en_s    = 1'b0;
        end else begin
            in_ready_s = bank_writable(state_r[wr_bank_r]);
            wr_en_s    = in_valid && in_ready_s;
            // A new read may only launch if the output slot is empty or is
            // being emptied this cycle.
            rd_en_s    = bank_readable(state_r[rd_bank_r]) && (!out_valid_r || out_ready);
        end
    end

    // Per-bank occupancy flags.
    always_comb begin
        bank_full_s = 2'b00;
        for (int b = 0; b < 2; b++) begin
            bank_full_s[b] = bank_readable(state_r[b]);
        end
    end

    // Bank state machine, pointers, counters and the output-valid register.
    // Write and read never target the same bank in one cycle, so the two
    // state updates below cannot collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r[0]  <= BANK_FREE;
            state_r[1]  <= BANK_FREE;
            wr_bank_r   <= 1'b0;
            rd_bank_r   <= 1'b0;
            wr_cnt_r    <= {ADDR_W{1'b0}};
            rd_cnt_r    <= {ADDR_W{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                if (wr_cnt_r == LAST_IDX) begin
                    state_r[wr_bank_r] <= BANK_FULL;
                    wr_cnt_r           <= {ADDR_W{1'b0}};
                    wr_bank_r          <= ~wr_bank_r;
                end else begin
                    state_r[wr_bank_r] <= BANK_FILLING;
                    wr_cnt_r           <= wr_cnt_r + ADDR_W'(1);
                end
            end
            if (rd_en_s) begin
                if (rd_cnt_r == LAST_IDX) begin
                    state_r[rd_bank_r] <= BANK_FREE;
                    rd_cnt_r           <= {ADDR_W{1'b0}};
                    rd_bank_r          <= ~rd_bank_r;
                end else begin
                    state_r[rd_bank_r] <= BANK_DRAINING;
                    rd_cnt_r           <= rd_cnt_r + ADDR_W'(1);
                end
            end
            out_valid_r <= rd_en_s || (out_valid_r && !out_ready);
        end
    end

    assign in_ready  = in_ready_s;
    assign wr_en     = wr_en_s;
    assign wr_bank   = wr_bank_r;
    assign wr_addr   = wr_cnt_r;
    assign rd_en     = rd_en_s;
    assign rd_bank   = rd_bank_r;
    assign rd_addr   = rd_cnt_r;
    assign out_valid = out_valid_r;
    assign bank_full = bank_full_s;
    assign level     = {1'b0, bank_full_s[0]} + {1'b0, bank_full_s[1]};

endmodule

// File: tb/tb_pingpong_ctrl.sv
// tb_pingpong_ctrl
// Self-checking bench: controller plus two bank RAMs. Accepted words are
// pushed into a scoreboard queue; a negedge monitor pops and compares every
// consumer transfer and checks addressing/release rules from a word-count
// model of the buffer.
module tb_pingpong_ctrl;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              wr_en, wr_bank, rd_en, rd_bank;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        bank_full;
    logic [1:0]        level;
    logic [DATA_W-1:0] rdata0, rdata1, out_data;
    logic              rd_bank_q = 1'b0;

    always #5 clk = ~clk;

    pingpong_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
        .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .bank_full(bank_full), .level(level)
    );

    pingpong_bank_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) ram0 (
        .clk(clk), .reset(reset), .we(wr_en && !wr_bank), .waddr(wr_addr), .wdata(in_data),
        .re(rd_en && !rd_bank), .raddr(rd_addr), .rdata(rdata0)
    );

    pingpong_bank_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) ram1 (
        .clk(clk), .reset(reset), .we(wr_en && wr_bank), .waddr(wr_addr), .wdata(in_data),
        .re(rd_en && rd_bank), .raddr(rd_addr), .rdata(rdata1)
    );

    // Remember which bank the current output word came from.
    always @(posedge clk) if (rd_en) rd_bank_q <= rd_bank;
    assign out_data = rd_bank_q ? rdata1 : rdata0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: counts of accepted / read-launched / delivered words.
    logic [DATA_W-1:0] exp_q[$];
    int acc_cnt = 0, rd_cnt = 0, out_cnt = 0, nc = 0;
    int lat_arm = 0, lat_done = 0, nc4 = 0, first_nc = 0, last_nc = 0;
    int or_mode = 0;

    // Monitor / scoreboard.
    always @(negedge clk) begin
        int a, r;
        nc++;
        if (reset) begin
            exp_q.delete();
            acc_cnt = 0; rd_cnt = 0; out_cnt = 0;
        end else begin
            a = acc_cnt; r = rd_cnt;
            if (out_valid && !out_ready) begin
                chk("rd_en_while_stalled", int'(rd_en), 0);
                chk("rd_addr_hold", int'(rd_addr), r % DEPTH);
            end
            if (rd_en) begin
                // Only words of completely filled banks may be read.
                chk("rd_released", int'(r < (a / DEPTH) * DEPTH), 1);
                chk("rd_addr", int'(rd_addr), r % DEPTH);
                chk("rd_bank", int'(rd_bank), (r / DEPTH) % 2);
                rd_cnt++;
            end
            if (wr_en) begin
                // At most two banks of words can be held un-read.
                chk("wr_room", int'(a < 2 * DEPTH + (r / DEPTH) * DEPTH), 1);
                chk("wr_addr", int'(wr_addr), a % DEPTH);
                chk("wr_bank", int'(wr_bank), (a / DEPTH) % 2);
                exp_q.push_back(in_data);
                if (lat_arm != 0 && a == DEPTH - 1) nc4 = nc;
                acc_cnt++;
            end
            if (lat_arm != 0 && lat_done == 0 && out_valid) begin
                chk("fill_to_out_latency", nc - nc4, 2);
                lat_done = 1;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("out_unexpected", int'(out_data), -1);
                end else begin
                    chk("out_data", int'(out_data), int'(exp_q.pop_front()));
                end
                if (out_cnt == 0) first_nc = nc;
                out_cnt++;
                last_nc = nc;
            end
        end
    end

    // Consumer: 0 = always ready, 1 = never, 2 = toggle, 3 = random.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (or_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                2:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        int   n;
        logic acc;
        in_valid = 1'b1; in_data = d; n = 0; acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1; n++;
        end
        if (!acc) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: word %0d not accepted, required accept", d);
        end
    endtask

    task automatic wait_drain(input int left);
        int n = 0;
        while (exp_q.size() > left && n < 300) begin tick(); n++; end
        chk("drain_remaining", exp_q.size(), left);
    endtask

    task automatic do_reset(input int cycles);
        in_valid = 1'b0; reset = 1'b1;
        repeat (cycles) tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 8'd0;

        // Reset values.
        repeat (2) tick();
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_rd_en", int'(rd_en), 0);
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", int'(in_ready), 1);
        tick();

        // Streaming 1..8, always ready.
        or_mode = 0; lat_arm = 1;
        for (int i = 1; i <= 8; i++) send(8'(i));
        in_valid = 1'b0;
        wait_drain(0);
        chk("stream_out_count", out_cnt, 8);
        chk("stream_no_gaps", last_nc - first_nc, 7);
        lat_arm = 0;
        chk("stream_latency_seen", lat_done, 1);

        // Backpressure fill: both banks full, word 9 waits for a drained bank.
        do_reset(1);
        or_mode = 1;
        for (int i = 1; i <= 8; i++) send(8'(i));
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_level", int'(level), 2);
        chk("bp_in_ready", int'(in_ready), 0);
        chk("bp_bank_full", int'(bank_full), 3);
        tick();
        fork
            send(8'd9);
            begin repeat (3) tick(); or_mode = 0; end
        join
        in_valid = 1'b0;
        chk("bp_out_before_9", int'(out_cnt >= DEPTH), 1);
        wait_drain(1);

        // Producer gaps: bank 1 stays partially filled.
        do_reset(1);
        or_mode = 0;
        for (int i = 1; i <= 6; i++) send(8'(i));
        in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("gap_bank1_not_full", int'(bank_full[1]), 0);
            chk("gap_in_ready", int'(in_ready), 1);
            @(posedge clk); #1;
        end
        chk("gap_partial_held", out_cnt, 4);
        send(8'd7); send(8'd8);
        in_valid = 1'b0;
        wait_drain(0);
        chk("gap_out_count", out_cnt, 8);

        // Consumer stall: toggling out_ready.
        do_reset(1);
        or_mode = 2;
        for (int i = 1; i <= 4; i++) send(8'(i));
        in_valid = 1'b0;
        wait_drain(0);
        chk("stall_out_count", out_cnt, 4);

        // Reset mid-operation.
        do_reset(1);
        or_mode = 1;
        for (int i = 1; i <= 6; i++) send(8'(i));
        in_valid = 1'b0;
        do_reset(1);
        @(negedge clk);
        chk("midrst_level", int'(level), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_wr_addr", int'(wr_addr), 0);
        @(posedge clk); #1;
        or_mode = 0;
        for (int i = 1; i <= 4; i++) send(8'(i));
        in_valid = 1'b0;
        wait_drain(0);
        chk("midrst_out_count", out_cnt, 4);

        // Random traffic against the scoreboard.
        do_reset(1);
        or_mode = 3;
        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                in_valid = 1'b0;
                repeat (gap) tick();
            end
            send(8'($urandom));
        end
        in_valid = 1'b0;
        wait_drain(0);
        chk("rand_out_count", out_cnt, 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
